// File: rtl/aib_axi_link_ctrl.sv
// AIB-to-AXI link bring-up sequencer: adapter reset, config-done, wait for all
// transfer enables, one-shot credit load, then link_up; bounded retry to FAIL.
module aib_axi_link_ctrl #(
  parameter int CONF_DLY  = 16,
  parameter int TIMEOUT   = 4096,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 16
) (
  input  logic       clk_wr,
  input  logic       rst_wr_n,
  input  logic       link_en,
  input  logic [3:0] xfer_en,
  output logic       o_adapt_rst_n,
  output logic       o_conf_done,
  output logic       o_credit_load,
  output logic       o_link_up,
  output logic       o_err,
  output logic [3:0] o_retry_cnt,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_HOLD = 3'd1,
    S_CONF     = 3'd2,
    S_WAIT     = 3'd3,
    S_LOAD     = 3'd4,
    S_UP       = 3'd5,
    S_BACKOFF  = 3'd6,
    S_FAIL     = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] CONF_LAST = CNT_W'(CONF_DLY - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [4:0]       MAX_R     = 5'(MAX_RETRY);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_retry, w_retry_nxt;
  logic [4:0]       w_retry_inc;
  logic             w_all_xfer;

  assign w_all_xfer  = (xfer_en == 4'hF);
  // One bit wider so the FAIL decision is correct even at the saturation point.
  assign w_retry_inc = 5'(r_retry) + 5'd1;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_ONE;
    w_retry_nxt = r_retry;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt   = '0;
        w_retry_nxt = '0;
        if (link_en) w_state_nxt = S_RST_HOLD;
      end
      S_RST_HOLD: begin
        if (r_cnt == CONF_LAST) begin
          w_state_nxt = S_CONF;
          w_cnt_nxt   = '0;
        end
      end
      S_CONF: begin
        if (r_cnt == CONF_LAST) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        // A full enable set on the timeout cycle still wins over the retry.
        if (w_all_xfer) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = S_BACKOFF;
          w_cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_UP;
        w_cnt_nxt   = '0;
      end
      S_UP: begin
        w_cnt_nxt = '0;
        if (!w_all_xfer) w_state_nxt = S_BACKOFF;
      end
      S_BACKOFF: begin
        w_cnt_nxt   = '0;
        w_retry_nxt = (r_retry == 4'hF) ? r_retry : w_retry_inc[3:0];
        w_state_nxt = (w_retry_inc > MAX_R) ? S_FAIL : S_RST_HOLD;
      end
      S_FAIL: begin
        w_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // Dropping the request aborts from anywhere, including LOAD.
    if (!link_en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end
  end

  always_comb begin
    o_adapt_rst_n = 1'b0;
    o_conf_done   = 1'b0;
    o_credit_load = 1'b0;
    o_link_up     = 1'b0;
    o_err         = 1'b0;
    case (r_state)
      S_CONF: o_adapt_rst_n = 1'b1;
      S_WAIT: begin
        o_adapt_rst_n = 1'b1;
        o_conf_done   = 1'b1;
      end
      S_LOAD: begin
        o_adapt_rst_n = 1'b1;
        o_conf_done   = 1'b1;
        o_credit_load = 1'b1;
      end
      S_UP: begin
        o_adapt_rst_n = 1'b1;
        o_conf_done   = 1'b1;
        o_link_up     = 1'b1;
      end
      S_FAIL:  o_err = 1'b1;
      default: ;
    endcase
  end

  assign o_retry_cnt = r_retry;
  assign o_state     = r_state;

endmodule
